// File: rtl/add_4_bit.sv
// add_4_bit: registered 4-bit unsigned adder with carry-out.
// Operands are summed through a full carry-lookahead network (carry-in tied
// to 0). The sum and carry are captured one clock after a valid input and
// held while valid_in is low. valid_out is a registered copy of valid_in.
// Optional feature: define ADD_4_BIT_OVF_EN to add a registered signed
// two's-complement overflow flag (overflow_out = c4 ^ c3).
module add_4_bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    output logic [3:0] sum_out,
    output logic       carry_out,
`ifdef ADD_4_BIT_OVF_EN
    output logic       overflow_out,
`endif
    output logic       valid_out
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    logic [3:0] sum_nxt;

    // Generate/propagate terms and flattened lookahead carries (no ripple chain)
    always_comb begin
        g       = a_in & b_in;
        p       = a_in ^ b_in;
        c       = '0;
        c[1]    = g[0];
        c[2]    = g[1] | (p[1] & g[0]);
        c[3]    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
        c[4]    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
        sum_nxt = p ^ c[3:0];
    end

    // Result registers: capture on valid input, otherwise hold the last result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else if (valid_in) begin
            sum_out   <= sum_nxt;
            carry_out <= c[4];
        end
    end

    // valid_out tracks valid_in every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
        end
    end

`ifdef ADD_4_BIT_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_out <= 1'b0;
        end else if (valid_in) begin
            overflow_out <= c[4] ^ c[3];
        end
    end
`endif

endmodule

// File: tb/tb_add_4_bit.sv
// Testbench for add_4_bit: scoreboard of expected results, pushed when a valid
// operand pair is driven and popped when valid_out is seen.
// Build with +define+ADD_4_BIT_OVF_EN to also check overflow_out.
module tb_add_4_bit;

    logic       clk;
    logic       rst_n;
    logic       valid_in;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic [3:0] sum_out;
    logic       carry_out;
    logic       valid_out;
`ifdef ADD_4_BIT_OVF_EN
    logic       overflow_out;
`endif

    typedef struct packed {
        logic [4:0] s;
        logic       o;
    } exp_t;

    exp_t       sb[$];
    exp_t       hold;
    int         total = 0;
    int         bad   = 0;

    add_4_bit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .a_in         (a_in),
        .b_in         (b_in),
        .sum_out      (sum_out),
        .carry_out    (carry_out),
`ifdef ADD_4_BIT_OVF_EN
        .overflow_out (overflow_out),
`endif
        .valid_out    (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        e.s = {1'b0, a} + {1'b0, b};
        e.o = (a[3] == b[3]) && (e.s[3] != a[3]);
        return e;
    endfunction

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic v);
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        valid_in = v;
        if (v) sb.push_back(model(a, b));
    endtask

    // Monitor: compare outputs against the scoreboard or the held result
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            hold = '0;
            check("rst_sum", sum_out, 0);
            check("rst_carry", carry_out, 0);
            check("rst_valid", valid_out, 0);
`ifdef ADD_4_BIT_OVF_EN
            check("rst_ovf", overflow_out, 0);
`endif
        end else if (valid_out) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                hold = e;
                check("sum", sum_out, e.s[3:0]);
                check("carry", carry_out, e.s[4]);
`ifdef ADD_4_BIT_OVF_EN
                check("ovf", overflow_out, e.o);
`endif
            end
        end else begin
            check("hold_sum", sum_out, hold.s[3:0]);
            check("hold_carry", carry_out, hold.s[4]);
`ifdef ADD_4_BIT_OVF_EN
            check("hold_ovf", overflow_out, hold.o);
`endif
        end
    end

    initial begin
        // Reset held with live operands
        rst_n    = 1'b0;
        valid_in = 1'b1;
        a_in     = 4'h5;
        b_in     = 4'h3;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_sum", sum_out, 0);
        check("rst_hold_valid", valid_out, 0);
        valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Toggle sweep: a toggles every 10 ns, b every 20 ns
        for (int unsigned i = 0; i < 8; i++)
            drive(i[0] ? 4'hF : 4'h0, i[1] ? 4'hF : 4'h0, 1'b1);

        // Wrap-around and boundary values
        drive(4'hF, 4'h1, 1'b1);
        drive(4'h8, 4'h8, 1'b1);
        drive(4'h0, 4'h0, 1'b1);

        // Hold: operand changes with valid_in low must not move outputs
        drive(4'h3, 4'h4, 1'b1);
        drive(4'hA, 4'h4, 1'b0);
        drive(4'hA, 4'hC, 1'b0);
        drive(4'h1, 4'h9, 1'b0);

        // Overflow cases
        drive(4'h7, 4'h1, 1'b1);
        drive(4'h7, 4'hF, 1'b1);
        drive(4'h8, 4'hF, 1'b1);

        // Exhaustive, back-to-back
        for (int unsigned a = 0; a < 16; a++)
            for (int unsigned b = 0; b < 16; b++)
                drive(a[3:0], b[3:0], 1'b1);

        // Random mix of valid and idle cycles
        for (int unsigned k = 0; k < 64; k++)
            drive(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));

        // Asynchronous reset mid-cycle after a nonzero result
        drive(4'hF, 4'hF, 1'b1);
        @(posedge clk);
        #2;
        check("pre_async_sum", sum_out, 4'hE);
        rst_n = 1'b0;
        #1;
        check("async_sum", sum_out, 0);
        check("async_carry", carry_out, 0);
        check("async_valid", valid_out, 0);
`ifdef ADD_4_BIT_OVF_EN
        check("async_ovf", overflow_out, 0);
`endif
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // First result after release
        drive(4'h9, 4'h9, 1'b1);
        drive(4'h2, 4'h3, 1'b1);
        drive(4'h0, 4'h0, 1'b0);
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
